// File: rtl/periph_pkg.sv
// Shared definitions for the memory-mapped peripheral responder:
// register offsets (addr[4:2]), TCON bit positions and UART FSM state codes.
package periph_pkg;

    // Register offsets as decoded from addr[4:2].
    localparam logic [2:0] PERIPH_TH       = 3'd0;
    localparam logic [2:0] PERIPH_TL       = 3'd1;
    localparam logic [2:0] PERIPH_TCON     = 3'd2;
    localparam logic [2:0] PERIPH_LED      = 3'd3;
    localparam logic [2:0] PERIPH_SWITCH   = 3'd4;
    localparam logic [2:0] PERIPH_DIGI     = 3'd5;
    localparam logic [2:0] PERIPH_UART_TXD = 3'd6;
    localparam logic [2:0] PERIPH_UART_CON = 3'd7;

    // TCON bit positions.
    localparam int unsigned TCON_EN     = 0;
    localparam int unsigned TCON_IRQ_EN = 1;
    localparam int unsigned TCON_IRQ_ST = 2;

    // UART transmitter state encoding.
    typedef logic [1:0] uart_state_t;
    localparam uart_state_t UART_IDLE  = 2'd0;
    localparam uart_state_t UART_START = 2'd1;
    localparam uart_state_t UART_DATA  = 2'd2;
    localparam uart_state_t UART_STOP  = 2'd3;

endpackage

// File: rtl/periph_bus_slave_uart_tx.sv
// 8N1 serial transmitter. A start pulse while idle sends one frame:
// start bit, 8 data bits LSB first, stop bit, each CLK_DIV cycles long.
// The data input must be held stable for the whole frame.
module uart_tx
    import periph_pkg::*;
#(
    parameter int unsigned CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done_pulse,
    output logic       txd
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

    uart_state_t     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic            bit_end;

    assign bit_end = (cnt_q == CntLast);

    // Next-state logic: baud counter runs in every non-idle state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        case (state_q)
            UART_IDLE: begin
                cnt_d = '0;
                bit_d = 3'd0;
                if (start) begin
                    state_d = UART_START;
                end
            end
            UART_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = UART_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UART_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = UART_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = UART_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // State registers; async reset aborts any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= UART_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    // Line and status outputs decoded from registered state only, so txd
    // returns high as soon as reset clears the state.
    always_comb begin
        txd = 1'b1;
        case (state_q)
            UART_START: txd = 1'b0;
            UART_DATA:  txd = data[bit_q];
            default:    txd = 1'b1;
        endcase
        busy       = (state_q != UART_IDLE);
        done_pulse = (state_q == UART_STOP) && bit_end;
    end

endmodule

// File: rtl/periph_bus_slave.sv
// Memory-mapped peripheral responder: reload timer with interrupt, LED and
// 7-segment registers, synchronized switch input and an optional UART
// transmitter (built only when PERIPH_UART_EN is defined).
// Reads are combinational from addr[4:2]; writes commit on the clock edge.
module periph_bus_slave
    import periph_pkg::*;
#(
    parameter int unsigned CLK_DIV = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        we_i,
    output logic [31:0] data_o,
    input  logic [7:0]  switch_i,
    output logic [7:0]  led_o,
    output logic [11:0] digi_o,
    output logic        irq_o,
    output logic        uart_txd_o
);

    logic [2:0]  offset;
    logic        unused_addr;
    logic        wr_th, wr_tl, wr_tcon, wr_led, wr_digi;

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic [7:0]  sw_meta_q, sw_sync_q;
    logic        tl_max, irq_set;

    logic [31:0] uart_rd_txd, uart_rd_con;

    assign offset      = addr_i[4:2];
    assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};

    assign wr_th   = we_i && (offset == PERIPH_TH);
    assign wr_tl   = we_i && (offset == PERIPH_TL);
    assign wr_tcon = we_i && (offset == PERIPH_TCON);
    assign wr_led  = we_i && (offset == PERIPH_LED);
    assign wr_digi = we_i && (offset == PERIPH_DIGI);

    assign tl_max  = (tl_q == 32'hFFFF_FFFF);
    assign irq_set = tcon_q[TCON_EN] && tl_max && tcon_q[TCON_IRQ_EN];

    // Timer and GPIO next state. A bus write to TL beats count/reload; an
    // overflow setting the status bit beats a write that clears it.
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        led_d  = led_q;
        digi_d = digi_q;
        if (wr_th) begin
            th_d = data_i;
        end
        if (wr_tl) begin
            tl_d = data_i;
        end else if (tcon_q[TCON_EN]) begin
            tl_d = tl_max ? th_q : tl_q + 32'd1;
        end
        if (wr_tcon) begin
            tcon_d = data_i[2:0];
        end
        if (irq_set) begin
            tcon_d[TCON_IRQ_ST] = 1'b1;
        end
        if (wr_led) begin
            led_d = data_i[7:0];
        end
        if (wr_digi) begin
            digi_d = data_i[11:0];
        end
    end

    // Timer, GPIO and switch synchronizer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            led_q     <= '0;
            digi_q    <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digi_q    <= digi_d;
            sw_meta_q <= switch_i;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign led_o  = led_q;
    assign digi_o = digi_q;
    assign irq_o  = tcon_q[TCON_IRQ_ST] & tcon_q[TCON_IRQ_EN];

`ifdef PERIPH_UART_EN
    logic       uart_busy, uart_done_pulse, uart_start, wr_ucon;
    logic       done_q;
    logic [7:0] txd_byte_q;

    // Writes while a frame is in flight are dropped, byte register included.
    assign uart_start = we_i && (offset == PERIPH_UART_TXD) && !uart_busy;
    assign wr_ucon    = we_i && (offset == PERIPH_UART_CON);

    // Byte latch and sticky done flag; done-set beats a clearing write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txd_byte_q <= '0;
            done_q     <= 1'b0;
        end else begin
            if (uart_start) begin
                txd_byte_q <= data_i[7:0];
            end
            if (uart_done_pulse) begin
                done_q <= 1'b1;
            end else if (wr_ucon) begin
                done_q <= 1'b0;
            end
        end
    end

    uart_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_uart_tx (
        .clk        (clk),
        .rst        (rst),
        .start      (uart_start),
        .data       (txd_byte_q),
        .busy       (uart_busy),
        .done_pulse (uart_done_pulse),
        .txd        (uart_txd_o)
    );

    assign uart_rd_txd = {24'd0, txd_byte_q};
    assign uart_rd_con = {30'd0, done_q, uart_busy};
`else
    assign uart_txd_o  = 1'b1;
    assign uart_rd_txd = 32'd0;
    assign uart_rd_con = 32'd0;
`endif

    // Combinational read mux.
    always_comb begin
        data_o = 32'd0;
        case (offset)
            PERIPH_TH:       data_o = th_q;
            PERIPH_TL:       data_o = tl_q;
            PERIPH_TCON:     data_o = {29'd0, tcon_q};
            PERIPH_LED:      data_o = {24'd0, led_q};
            PERIPH_SWITCH:   data_o = {24'd0, sw_sync_q};
            PERIPH_DIGI:     data_o = {20'd0, digi_q};
            PERIPH_UART_TXD: data_o = uart_rd_txd;
            default:         data_o = uart_rd_con;
        endcase
    end

endmodule

// File: tb/tb_periph_bus_slave.sv
// Directed self-checking bench for periph_bus_slave (CLK_DIV = 4).
// UART checks adapt to whether PERIPH_UART_EN is defined.
module tb_periph_bus_slave;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic [7:0]  sw;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irq;
    logic        txd;

    int n_checks = 0;
    int n_fail   = 0;

    periph_bus_slave #(
        .CLK_DIV (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr_i     (addr),
        .data_i     (wdata),
        .we_i       (we),
        .data_o     (rdata),
        .switch_i   (sw),
        .led_o      (led),
        .digi_o     (digi),
        .irq_o      (irq),
        .uart_txd_o (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] off_addr(input logic [2:0] off);
        return 32'h4000_0000 | (32'(off) << 2);
    endfunction

    task automatic bus_write(input logic [2:0] off, input logic [31:0] d);
        @(negedge clk);
        addr  = off_addr(off);
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [2:0] off, input logic [31:0] exp);
        addr = off_addr(off);
        #1;
        check(tag, rdata, exp);
    endtask

    // Expected frame for 0xA5: start, LSB-first data, stop.
    logic [9:0] frame_a5;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        frame_a5 = 10'b1_1010_0101_0;  // bit i = serial position i
        rst   = 1'b1;
        addr  = 32'h4000_0000;
        wdata = 32'd0;
        we    = 1'b0;
        sw    = 8'd0;
        #1;
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_led", {24'd0, led}, 32'd0);
        check("rst_digi", {20'd0, digi}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        read_check("rd_th0", 3'd0, 32'd0);
        read_check("rd_tl0", 3'd1, 32'd0);
        read_check("rd_tcon0", 3'd2, 32'd0);
        read_check("rd_led0", 3'd3, 32'd0);
        read_check("rd_sw0", 3'd4, 32'd0);
        read_check("rd_digi0", 3'd5, 32'd0);
        read_check("rd_utxd0", 3'd6, 32'd0);
        read_check("rd_ucon0", 3'd7, 32'd0);

        // GPIO and switch synchronizer.
        bus_write(3'd3, 32'h0000_005A);
        bus_write(3'd5, 32'h0000_03FF);
        check("led_out", {24'd0, led}, 32'h5A);
        check("digi_out", {20'd0, digi}, 32'h3FF);
        read_check("rd_led", 3'd3, 32'h5A);
        read_check("rd_digi", 3'd5, 32'h3FF);
        @(negedge clk);
        sw = 8'hC3;
        @(posedge clk);
        #1;
        read_check("sw_1cyc", 3'd4, 32'd0);
        @(posedge clk);
        #1;
        read_check("sw_2cyc", 3'd4, 32'hC3);
        bus_write(3'd4, 32'h0000_0011);
        read_check("sw_ro", 3'd4, 32'hC3);

        // Timer overflow, reload and interrupt.
        bus_write(3'd0, 32'hFFFF_FFF0);
        bus_write(3'd1, 32'hFFFF_FFFC);
        bus_write(3'd2, 32'd3);
        check("tmr_irq_pre", {31'd0, irq}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        read_check("tmr_reload", 3'd1, 32'hFFFF_FFF0);
        read_check("tmr_tcon7", 3'd2, 32'd7);
        check("tmr_irq", {31'd0, irq}, 32'd1);
        bus_write(3'd2, 32'd3);
        check("tmr_irq_clr", {31'd0, irq}, 32'd0);
        read_check("tmr_tcon3", 3'd2, 32'd3);

        // Clearing write landing on the overflow cycle: set wins.
        bus_write(3'd2, 32'd0);
        bus_write(3'd1, 32'hFFFF_FFFC);
        bus_write(3'd2, 32'd3);
        repeat (3) @(posedge clk);
        bus_write(3'd2, 32'd3);
        read_check("ovf_set_wins", 3'd2, 32'd7);
        check("ovf_irq", {31'd0, irq}, 32'd1);
        read_check("ovf_reload", 3'd1, 32'hFFFF_FFF0);

        // TL write beats increment while running.
        bus_write(3'd1, 32'h0000_0100);
        read_check("tl_wr_wins", 3'd1, 32'h100);
        @(posedge clk);
        #1;
        read_check("tl_inc", 3'd1, 32'h101);
        bus_write(3'd2, 32'd1);
        check("irq_en_off", {31'd0, irq}, 32'd0);

`ifdef PERIPH_UART_EN
        // Frame for 0xA5, with a dropped mid-frame write of 0x3C.
        bus_write(3'd6, 32'h0000_00A5);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check($sformatf("txd_bit%0d_c%0d", i / 4, i % 4), {31'd0, txd},
                  {31'd0, frame_a5[i/4]});
            if (i == 12) begin
                addr  = off_addr(3'd6);
                wdata = 32'h0000_003C;
                we    = 1'b1;
            end
            if (i == 13) begin
                we = 1'b0;
            end
            if (i == 20) begin
                read_check("ucon_busy", 3'd7, 32'd1);
            end
            if (i == 30) begin
                read_check("utxd_kept", 3'd6, 32'hA5);
            end
        end
        @(posedge clk);
        #1;
        read_check("ucon_done", 3'd7, 32'd2);
        check("txd_idle", {31'd0, txd}, 32'd1);
        bus_write(3'd7, 32'd0);
        read_check("ucon_clr", 3'd7, 32'd0);

        // Reset in the middle of a frame.
        bus_write(3'd6, 32'h0000_0000);
        repeat (6) @(negedge clk);
        check("txd_low_mid", {31'd0, txd}, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_mid_txd", {31'd0, txd}, 32'd1);
        read_check("rst_mid_con", 3'd7, 32'd0);
        read_check("rst_mid_tl", 3'd1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_txd", {31'd0, txd}, 32'd1);
            read_check("post_rst_busy", 3'd7, 32'd0);
        end
`else
        // UART disabled: offsets 6/7 read zero and writes are ignored.
        bus_write(3'd6, 32'h0000_00A5);
        read_check("nouart_txd_rd", 3'd6, 32'd0);
        bus_write(3'd7, 32'h0000_0003);
        read_check("nouart_con_rd", 3'd7, 32'd0);
        repeat (8) begin
            @(negedge clk);
            check("nouart_line", {31'd0, txd}, 32'd1);
        end
        rst = 1'b1;
        #1;
        read_check("rst_mid_tl", 3'd1, 32'd0);
        check("rst_mid_led", {24'd0, led}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
`endif
        check("final_irq", {31'd0, irq}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/periph_bus_slave.md
# periph_bus_slave

Memory-mapped peripheral responder on the MEM-stage data bus, selected when address bit 30 is 1. Provides a reload timer with interrupt, LED and 7-segment output registers, a switch input register and an 8N1 UART transmitter. Reads are combinational so the MEM stage can capture them in the same cycle. Writes commit on the clock edge. `irq_o` feeds the CPU's hardware-interrupt input, which appears in Cause[15:8].

## Interface
- `CLK_DIV`, default 868: clock cycles per UART bit (100 MHz / 115200).
- `clk`, in, 1: system clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `addr_i`, in, 32: word byte address from the MEM stage. Only bits [4:2] are decoded.
- `data_i`, in, 32: store data.
- `we_i`, in, 1: write enable. Already qualified by bit 30 and by exception suppression upstream.
- `data_o`, out, 32: combinational read data.
- `switch_i`, in, 8: board switches. Sampled through a 2-flop synchronizer.
- `led_o`, out, 8: LED register.
- `digi_o`, out, 12: 7-segment register (anode[11:8], segment[7:0]).
- `irq_o`, out, 1: timer interrupt request, level.
- `uart_txd_o`, out, 1: serial output, idle high.

## Operation
Register map. Offsets are from 0x40000000 and are given as addr_i[4:2]:
- 0 TH (R/W, 32): reload value.
- 1 TL (R/W, 32): counter.
- 2 TCON (R/W, bits [2:0]): bit 0 = enable, bit 1 = irq enable, bit 2 = irq status. Reads return zero-extended.
- 3 LED (R/W, 8).
- 4 SWITCH (RO): returns the synchronized switches.
- 5 DIGI (R/W, 12).
- 6 UART_TXD (W; reads return the last byte written).
- 7 UART_CON (RO bit 0 = busy; bit 1 = done, sticky, cleared by any write to UART_CON).
- Writes to RO registers are ignored.

Timer:
- When TCON[0] is 1, TL increments every cycle.
- When TL == 0xFFFFFFFF: TL <= TH. If TCON[1] is 1, TCON[2] <= 1.
- `irq_o` = TCON[2] & TCON[1].
- Software clears the interrupt by writing TCON with bit 2 = 0.

Timer simultaneous events:
- Bus write to TL in the same cycle as increment or reload: the write wins.
- Bus write to TCON clearing bit 2 in the same cycle as an overflow that sets it: the set wins, so no interrupt is lost. Bits [1:0] still take the written value.

UART transmitter, state machine IDLE -> START -> DATA(8 bits) -> STOP -> IDLE:
- A write to UART_TXD in IDLE latches the byte and enters START.
- A write to UART_TXD while busy is dropped. The byte register is not updated.
- Each state or bit lasts CLK_DIV cycles. Bit order is LSB first. STOP drives 1.
- Leaving STOP sets done = 1.
- busy = (state != IDLE).
- Done-set and a UART_CON write in the same cycle: the set wins.

## Timing
- Read latency 0: `data_o` is combinational from `addr_i` and the register state.
- Writes take effect on the rising edge where `we_i` = 1. A read of the same address in the next cycle returns the new value.
- SWITCH reflects `switch_i` 2 cycles after it changes.
- Reset values: TH = TL = 0; TCON = 0; LED = 0; DIGI = 0; synchronizer = 0; UART state IDLE; baud counter = 0; bit index = 0; done = 0; txd byte = 0.
- Outputs under reset: `uart_txd_o` = 1; `irq_o` = 0; `led_o` = 0; `digi_o` = 0.
- Reset asserted mid-frame aborts the frame immediately. `uart_txd_o` returns high asynchronously.
- First start-bit edge: `uart_txd_o` falls on the edge after the accepting write.
- Frame length: 10 × CLK_DIV cycles from that edge to the return to IDLE.
- Baud counter width: $clog2(CLK_DIV).

## Configuration
- `PERIPH_UART_EN` defined: UART registers and the `uart_tx` instance are built.
- `PERIPH_UART_EN` undefined:
  - `uart_txd_o` is tied to 1.
  - Offsets 6 and 7 read 0.
  - Writes to offsets 6 and 7 are ignored.
  - No UART logic is synthesized.

## Structure
- Shared package `periph_pkg`:
  - Register offset constants (PERIPH_TH … PERIPH_UART_CON).
  - TCON bit indices.
  - UART state enum.
- Sub-module `uart_tx`: ports clk, rst, start, data[7:0], busy, done_pulse, txd, parameter CLK_DIV.
- Top level holds decode, the timer, GPIO registers and the done/TXD registers.

## Test plan
- Reset, then read all offsets -> TH, TL, TCON, LED and DIGI read 0. `uart_txd_o` = 1. `irq_o` = 0.
- Write TH = 0xFFFFFFF0, TL = 0xFFFFFFFC, TCON = 3 -> TL reads 0xFFFFFFF0 after 4 cycles. TCON reads 7. `irq_o` = 1. Write TCON = 3 -> `irq_o` = 0 next cycle.
- Same setup as above, with a TCON = 3 write landing exactly on the overflow cycle -> TCON[2] remains 1.
- Build with CLK_DIV = 4 and `PERIPH_UART_EN` defined. Write UART_TXD = 0xA5 -> serial sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. UART_CON reads 1 during the frame and 2 after it. A second write of 0x3C mid-frame is dropped.
- Write LED = 0x5A and DIGI = 0x3FF; drive `switch_i` = 0xC3 -> `led_o` = 0x5A, `digi_o` = 0x3FF. SWITCH reads 0xC3 two cycles after `switch_i` changes.
- Assert `rst` mid-frame -> `uart_txd_o` = 1 immediately. After release, busy = 0.
